enc16to4_seq: RTL and testbench

//  Sequential 16-to-4 encoder; companion/inverse of the 4-to-16 decoder (dec4to16two).

---
 rtl/enc16to4_seq.sv | 125 ++++++++++++
 tb/tb_enc16to4_seq.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/enc16to4_seq.sv
// Sequential N-to-W priority encoder: captures a request vector and streams the
// index of every set bit, one code per valid/ready transfer.
module enc16to4_seq #(
  parameter int N             = 16,
  parameter int W             = $clog2(N),
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] req,
  input  logic         ready,
  output logic [W-1:0] code,
  output logic         valid,
  output logic         last,
  output logic         busy,
  output logic         none
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] EMIT = 1'b1;

  logic [0:0]   state_q, state_d;
  logic [N-1:0] pending_q, pending_d;
  logic [W-1:0] code_q, code_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic         none_q, none_d;

  logic [N-1:0] remaining;
  logic [N-1:0] emitted_mask;

  // Later assignments win, so scan direction selects the priority end.
  function automatic logic [W-1:0] pick(input logic [N-1:0] vec);
    logic [W-1:0] idx;
    idx = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < N; i++) begin
        if (vec[i]) idx = W'(i);
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (vec[i]) idx = W'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic single_bit(input logic [N-1:0] vec);
    return (vec != '0) && ((vec & (vec - N'(1))) == '0);
  endfunction

  assign emitted_mask = N'(1) << code_q;
  assign remaining    = pending_q & ~emitted_mask;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    code_d    = code_q;
    valid_d   = valid_q;
    last_d    = last_q;
    none_d    = none_q;

    if (en) begin
      none_d = 1'b0;
      case (state_q)
        IDLE: begin
          if (load) begin
            if (req != '0) begin
              pending_d = req;
              code_d    = pick(req);
              valid_d   = 1'b1;
              last_d    = single_bit(req);
              state_d   = EMIT;
            end else begin
              none_d = 1'b1;
            end
          end
        end
        EMIT: begin
          if (valid_q && ready) begin
            pending_d = remaining;
            if (last_q) begin
              state_d = IDLE;
              valid_d = 1'b0;
              last_d  = 1'b0;
            end else begin
              code_d = pick(remaining);
              last_d = single_bit(remaining);
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      code_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      none_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      code_q    <= code_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      none_q    <= none_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign last  = last_q;
  assign busy  = (state_q == EMIT);
  assign none  = none_q;

endmodule

// File: tb/tb_enc16to4_seq.sv
// Scoreboard bench for enc16to4_seq: a reference model queues the expected code
// stream per accepted vector; a negedge monitor compares and pops on transfers.
module tb_enc16to4_seq;
  localparam int N  = 16;
  localparam int W  = 4;
  localparam bit PH = 1'b0;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         load = 1'b0;
  logic [N-1:0] req = '0;
  logic         ready = 1'b0;
  logic [W-1:0] code;
  logic         valid;
  logic         last;
  logic         busy;
  logic         none;

  enc16to4_seq #(.N(N), .W(W), .PRIORITY_HIGH(PH)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .req(req), .ready(ready),
    .code(code), .valid(valid), .last(last), .busy(busy), .none(none)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] code;
    logic         last;
  } exp_t;

  exp_t sb[$];
  int   outstanding = 0;
  bit   none_exp = 1'b0;
  bit   mon_on = 1'b0;
  int   checks = 0;
  int   errors = 0;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  // Expected stream: set-bit indices in priority order, final one flagged last.
  function automatic void push_vector(input logic [N-1:0] v);
    int idx[$];
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (PH) idx.push_front(i);
        else    idx.push_back(i);
      end
    end
    for (int k = 0; k < idx.size(); k++) begin
      exp_t e;
      e.code = W'(idx[k]);
      e.last = (k == idx.size() - 1);
      sb.push_back(e);
    end
  endfunction

  // Reference model, evaluated on the same edge the DUT samples its inputs.
  always @(posedge clk) begin
    bit busy_pre;
    if (rst) begin
      sb.delete();
      outstanding = 0;
      none_exp    = 1'b0;
    end else if (en) begin
      busy_pre = (outstanding > 0);
      none_exp = 1'b0;
      if (busy_pre && ready) outstanding--;
      if (!busy_pre && load) begin
        if (req != '0) begin
          push_vector(req);
          outstanding = $countones(req);
        end else begin
          none_exp = 1'b1;
        end
      end
    end
  end

  // Monitor: checks presented outputs each cycle, pops when a transfer will occur.
  always @(negedge clk) begin
    if (mon_on && !rst) begin
      chk("valid", int'(valid), int'(outstanding > 0));
      chk("busy", int'(busy), int'(outstanding > 0));
      chk("none", int'(none), int'(none_exp));
      if (valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_code", int'(code), -1);
        end else begin
          chk("code", int'(code), int'(sb[0].code));
          chk("last", int'(last), int'(sb[0].last));
          if (en && ready) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic cyc(input bit r, input bit e, input bit l,
                     input logic [N-1:0] q, input bit rd);
    @(posedge clk);
    #1;
    rst   = r;
    en    = e;
    load  = l;
    req   = q;
    ready = rd;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
  endtask

  initial begin
    logic [N-1:0] r;
    int sel;

    // T1 reset
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, '0, 1'b0);
    mon_on = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk("reset_code", int'(code), 0);
    chk("reset_last", int'(last), 0);

    // T2 one-hot sweep
    for (int i = 0; i < N; i++) begin
      cyc(1'b0, 1'b1, 1'b1, N'(1) << i, 1'b1);
      cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    end
    idle(2);

    // T3 multi-hot
    cyc(1'b0, 1'b1, 1'b1, 16'h8421, 1'b1);
    idle(6);

    // T4 backpressure
    cyc(1'b0, 1'b1, 1'b1, 16'h0006, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0, 1'b0);
    idle(4);

    // T5 zero vector
    cyc(1'b0, 1'b1, 1'b1, 16'h0000, 1'b1);
    idle(3);

    // T6 load while busy
    cyc(1'b0, 1'b1, 1'b1, 16'h0003, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h00F0, 1'b0);
    cyc(1'b0, 1'b1, 1'b1, 16'h00F0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 16'h00F0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    idle(3);
    // T6 stall mid-stream
    cyc(1'b0, 1'b1, 1'b1, 16'h000F, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, '0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1, 16'hFFFF, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, '0, 1'b1);
    idle(6);
    // T6 reset mid-vector
    cyc(1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b1);
    idle(3);
    cyc(1'b1, 1'b1, 1'b0, '0, 1'b1);
    idle(4);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: r = N'($urandom);
        1: r = N'(1) << $urandom_range(0, N - 1);
        2: r = '0;
        default: r = N'($urandom) & N'($urandom) & N'($urandom);
      endcase
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 9) != 0),
          ($urandom_range(0, 9) < 3), r, ($urandom_range(0, 9) < 7));
    end

    // Drain and confirm every expected code was delivered
    idle(40);
    @(negedge clk);
    chk("drain", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
